// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared multiplier engine.
// Zero operands bypass the engine; a stalled engine is aborted after TIMEOUT cycles.
module mul_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic [1:0]     gnt,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [2*W-1:0] result,
    output logic           err,
    output logic           mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic           mul_done,
    input  logic [2*W-1:0] mul_p,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t       state;
    state_t       state_nx;
    logic         owner;
    logic         last;
    logic         zgnt;
    logic [7:0]   cnt;
    logic         win;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         sel_zero;
    logic         tmo;
    logic         own_rdy;
    logic [1:0]   own_hot;

    // Arbitration: on a tie the requester not served last wins
    always_comb begin
        win      = req[1] & (~req[0] | ~last);
        sel_a    = win ? a1 : a0;
        sel_b    = win ? b1 : b0;
        sel_zero = (sel_a == '0) | (sel_b == '0);
        tmo      = (cnt == TLAST);
        own_rdy  = rsp_ready[owner];
        own_hot  = owner ? 2'b10 : 2'b01;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; mul_done wins over a simultaneous timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (req != 2'b00) state_nx = sel_zero ? RESP : ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (mul_done || tmo) state_nx = RESP;
            RESP:  if (own_rdy) state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered owner
    always_comb begin
        gnt       = 2'b00;
        rsp_valid = 2'b00;
        mul_start = 1'b0;
        busy      = (state != IDLE);
        if (state == ISSUE) begin
            gnt       = own_hot;
            mul_start = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid = own_hot;
            if (zgnt) gnt = own_hot;
        end
    end

    // Owner, operands, timeout counter, response and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner  <= 1'b0;
            last   <= 1'b1;
            zgnt   <= 1'b0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            zgnt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner  <= win;
                        mul_a  <= sel_a;
                        mul_b  <= sel_b;
                        result <= '0;
                        err    <= 1'b0;
                        zgnt   <= sel_zero;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (mul_done) begin
                        result <= mul_p;
                        err    <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (tmo) begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    end
                end
                RESP: if (own_rdy) last <= owner;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: default instance plus a TIMEOUT=4 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mul_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [1:0]     rsp_ready;
    logic           mul_done;
    logic [2*W-1:0] mul_p;

    logic [1:0]     gnt, rsp_valid;
    logic [2*W-1:0] result;
    logic           err, mul_start, busy;
    logic [W-1:0]   mul_a, mul_b;

    logic [1:0]     t_gnt, t_rsp_valid;
    logic [2*W-1:0] t_result;
    logic           t_err, t_mul_start, t_busy;
    logic [W-1:0]   t_mul_a, t_mul_b;

    int checks = 0;
    int errors = 0;

    logic [1:0] eh;
    logic [W-1:0] ea;
    logic [2*W-1:0] ep;

    always #5 clk = ~clk;

    mul_arbiter #(.W(W)) u0 (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .result(result), .err(err), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p), .busy(busy)
    );

    mul_arbiter #(.W(W), .TIMEOUT(4)) u4 (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(t_gnt), .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready),
        .result(t_result), .err(t_err), .mul_start(t_mul_start),
        .mul_a(t_mul_a), .mul_b(t_mul_b),
        .mul_done(mul_done), .mul_p(mul_p), .busy(t_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req       = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rsp_ready = 2'b00;
        mul_done  = 1'b0;
        mul_p     = '0;
        #3;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_result", result, 16'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_mul_a", mul_a, 8'd0);
        chk("rst_mul_b", mul_b, 8'd0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;

        // basic multiply, engine answers 42 about five cycles after start
        a0 = 8'd6; b0 = 8'd7; req = 2'b01;
        step();
        chk("basic_gnt", gnt, 2'b01);
        chk("basic_start", mul_start, 1'b1);
        chk("basic_mul_a", mul_a, 8'd6);
        chk("basic_mul_b", mul_b, 8'd7);
        chk("basic_busy", busy, 1'b1);
        req = 2'b00;
        step();
        chk("basic_gnt_drop", gnt, 2'b00);
        chk("basic_start_drop", mul_start, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("basic_wait_rv", rsp_valid, 2'b00);
        end
        mul_done = 1'b1; mul_p = 16'd42;
        step();
        mul_done = 1'b0;
        chk("basic_rv", rsp_valid, 2'b01);
        chk("basic_result", result, 16'd42);
        chk("basic_err", err, 1'b0);
        chk("basic_hold_a", mul_a, 8'd6);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("basic_rv_drop", rsp_valid, 2'b00);
        chk("basic_idle", busy, 1'b0);

        // round robin: req=11 twice from reset gives 0,1,0,1
        pulse_reset();
        a0 = 8'd3; b0 = 8'd5; a1 = 8'd4; b1 = 8'd2;
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || i == 2) req = 2'b11;
            eh = (i % 2 == 1) ? 2'b10 : 2'b01;
            ea = (i % 2 == 1) ? 8'd4 : 8'd3;
            ep = (i % 2 == 1) ? 16'd8 : 16'd15;
            step();
            chk("rr_gnt", gnt, eh);
            chk("rr_mul_a", mul_a, ea);
            req = req & ~eh;
            step();
            mul_done = 1'b1; mul_p = ep;
            step();
            mul_done = 1'b0;
            chk("rr_rv", rsp_valid, eh);
            chk("rr_result", result, ep);
            rsp_ready = eh;
            step();
            rsp_ready = 2'b00;
            chk("rr_rv_drop", rsp_valid, 2'b00);
        end

        // zero shortcut on requester 1
        a1 = 8'd0; b1 = 8'd9; req = 2'b10;
        step();
        chk("zero_start", mul_start, 1'b0);
        chk("zero_gnt", gnt, 2'b10);
        chk("zero_rv", rsp_valid, 2'b10);
        chk("zero_result", result, 16'd0);
        chk("zero_err", err, 1'b0);
        req = 2'b00;
        step();
        chk("zero_gnt_once", gnt, 2'b00);
        chk("zero_rv_hold", rsp_valid, 2'b10);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        chk("zero_rv_drop", rsp_valid, 2'b00);

        // response held by backpressure; non-owner ready and stray done ignored
        a0 = 8'd6; b0 = 8'd7; req = 2'b01;
        step();
        req = 2'b00;
        step();
        mul_done = 1'b1; mul_p = 16'h1234;
        step();
        chk("bp_rv0", rsp_valid, 2'b01);
        chk("bp_res0", result, 16'h1234);
        rsp_ready = 2'b10;
        mul_p = 16'h0999;
        for (int i = 0; i < 3; i++) begin
            step();
            mul_done = 1'b0;
            chk("bp_rv", rsp_valid, 2'b01);
            chk("bp_result", result, 16'h1234);
            chk("bp_err", err, 1'b0);
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("bp_rv_drop", rsp_valid, 2'b00);
        chk("bp_busy", busy, 1'b0);

        // asynchronous reset in WAIT, then tie goes to requester 0
        a0 = 8'd2; b0 = 8'd3; req = 2'b01;
        step();
        req = 2'b00;
        step();
        step();
        chk("ar_pre_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("ar_gnt", gnt, 2'b00);
        chk("ar_rv", rsp_valid, 2'b00);
        chk("ar_busy", busy, 1'b0);
        chk("ar_start", mul_start, 1'b0);
        chk("ar_mul_a", mul_a, 8'd0);
        chk("ar_mul_b", mul_b, 8'd0);
        chk("ar_result", result, 16'd0);
        chk("ar_err", err, 1'b0);
        reset = 1'b1;
        a1 = 8'd5; b1 = 8'd5; req = 2'b11;
        step();
        chk("ar_tie_gnt", gnt, 2'b01);
        req = 2'b00;
        pulse_reset();

        // TIMEOUT=4 instance: silent engine aborts after four WAIT cycles
        a0 = 8'd2; b0 = 8'd3; req = 2'b01;
        step();
        req = 2'b00;
        chk("to_start", t_mul_start, 1'b1);
        step();
        step();
        step();
        step();
        chk("to_w4_rv", t_rsp_valid, 2'b00);
        chk("to_w4_busy", t_busy, 1'b1);
        step();
        chk("to_rv", t_rsp_valid, 2'b01);
        chk("to_err", t_err, 1'b1);
        chk("to_result", t_result, 16'd0);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("to_rv_drop", t_rsp_valid, 2'b00);

        // done on the fourth WAIT cycle wins over the timeout
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        step();
        step();
        step();
        chk("tod_w4_rv", t_rsp_valid, 2'b00);
        mul_done = 1'b1; mul_p = 16'd6;
        step();
        mul_done = 1'b0;
        chk("tod_rv", t_rsp_valid, 2'b01);
        chk("tod_err", t_err, 1'b0);
        chk("tod_result", t_result, 16'd6);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("tod_busy", t_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // at most one grant and one response bit in any cycle
    always @(negedge clk) begin
        if (reset) begin
            if ($countones(gnt) > 1 || $countones(rsp_valid) > 1) begin
                errors++;
                $error("FAIL onehot: gnt %b rsp_valid %b required at most one bit", gnt, rsp_valid);
            end
        end
    end

endmodule
